as_imem_loader: RTL and testbench

Boot loader that fills `as_imem` through its write port. It accepts a byte stream with a valid/ready handshake, parses a 4-byte little-endian word-count header, and assembles little-endian instruction words. Each word is written to consecutive word-aligned addresses. The core is held in reset until the image is fully written. The block sits between the host/UART byte source and the `as_imem` `addr_i`/`data_i`/`wr_i` inputs.

---
 rtl/as_imem_loader_pkg.sv | 27 ++
 rtl/as_imem_loader_if.sv | 35 +++
 rtl/as_imem_loader_byte_packer.sv | 48 ++++
 rtl/as_imem_loader.sv | 186 ++++++++++++++++++
 tb/tb_as_imem_loader.sv | 211 +++++++++++++++++++++
 5 files changed

// File: rtl/as_imem_loader_pkg.sv
// Shared constants, state encoding and small helpers for the IMem boot loader.
package as_imem_loader_pkg;

  localparam int IMEM_ADDR_WIDTH   = 12;
  localparam int INSTR_WIDTH       = 32;
  localparam int IMEMDEPTH         = 1024;

  localparam int LOADER_HDR_BYTES  = 4;
  localparam int LOADER_WORD_BYTES = INSTR_WIDTH / 8;
  localparam int LOADER_CNT_W      = 8;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_HDR    = 3'd1,
    ST_DATA   = 3'd2,
    ST_WRITE  = 3'd3,
    ST_VERIFY = 3'd4,
    ST_DONE   = 3'd5,
    ST_ERR    = 3'd6
  } loader_state_t;

  // Larger of two widths; sizes the shared header/data shift register.
  function automatic int loader_max(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/as_imem_loader_if.sv
// Byte-stream, IMem write/readback and status bundle of the boot loader.
// master = loader side, slave = byte source / IMem / system side.
interface as_imem_loader_if
  import as_imem_loader_pkg::*;
#(
  parameter int imem_addr_width = IMEM_ADDR_WIDTH,
  parameter int instr_width     = INSTR_WIDTH
) ();

  logic                       start_i;
  logic [7:0]                 byte_i;
  logic                       byte_valid_i;
  logic                       byte_ready_o;
  logic [imem_addr_width-1:0] imem_addr_o;
  logic [instr_width-1:0]     imem_data_o;
  logic                       imem_wr_o;
  logic [instr_width-1:0]     imem_data_i;
  logic                       busy_o;
  logic                       done_o;
  logic                       err_o;
  logic                       core_hold_o;

  modport master (
    input  start_i, byte_i, byte_valid_i, imem_data_i,
    output byte_ready_o, imem_addr_o, imem_data_o, imem_wr_o,
           busy_o, done_o, err_o, core_hold_o
  );

  modport slave (
    output start_i, byte_i, byte_valid_i, imem_data_i,
    input  byte_ready_o, imem_addr_o, imem_data_o, imem_wr_o,
           busy_o, done_o, err_o, core_hold_o
  );

endinterface

// File: rtl/as_imem_loader_byte_packer.sv
// as_byte_packer: LSB-first byte-to-word shift register. Each accepted byte
// enters at the top and the register shifts right, so after N bytes the
// assembled little-endian value occupies the top N bytes. word_valid flags
// the accept of the last byte (counter at last_idx); the counter then wraps.
module as_byte_packer
  import as_imem_loader_pkg::*;
#(
  parameter int width = 32
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    clr,
  input  logic                    load,
  input  logic [7:0]              byte_in,
  input  logic [LOADER_CNT_W-1:0] last_idx,
  output logic [width-1:0]        word_next,
  output logic                    word_valid
);

  logic [width-1:0]        shift_r;
  logic [LOADER_CNT_W-1:0] cnt_r;

  // Next shift-register value and last-byte detection.
  always_comb begin
    word_next  = {byte_in, shift_r[width-1:8]};
    word_valid = 1'b0;
    if (load && (cnt_r == last_idx)) begin
      word_valid = 1'b1;
    end else begin
      word_valid = 1'b0;
    end
  end

  // Shift in accepted bytes; bytes are retained across valid gaps.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shift_r <= {width{1'b0}};
      cnt_r   <= {LOADER_CNT_W{1'b0}};
    end else if (clr) begin
      shift_r <= {width{1'b0}};
      cnt_r   <= {LOADER_CNT_W{1'b0}};
    end else if (load) begin
      shift_r <= word_next;
      cnt_r   <= word_valid ? {LOADER_CNT_W{1'b0}} : (cnt_r + {{(LOADER_CNT_W-1){1'b0}}, 1'b1});
    end
  end

endmodule

// File: rtl/as_imem_loader.sv
// as_imem_loader: boot loader filling IMem from a byte stream.
// Stream = 4-byte little-endian word count, then count little-endian words,
// written to consecutive word-aligned addresses. The core stays held in reset
// until the image is completely written.
// Optional macro AS_IMEM_LOADER_VERIFY_EN: adds a readback VERIFY cycle after
// every write; a readback mismatch ends the load in ERR.
module as_imem_loader
  import as_imem_loader_pkg::*;
#(
  parameter int imem_addr_width = as_imem_loader_pkg::IMEM_ADDR_WIDTH,
  parameter int instr_width     = as_imem_loader_pkg::INSTR_WIDTH,
  parameter int mdepth          = as_imem_loader_pkg::IMEMDEPTH
) (
  input logic               clk_i,
  input logic               rst_ni,
  as_imem_loader_if.master  bus
);

  localparam int PACK_W     = loader_max(32, instr_width);
  localparam int IDX_W      = $clog2(mdepth + 1);
  localparam int ADDR_IDX_W = imem_addr_width - 2;
  localparam int WORD_BYTES = instr_width / 8;

  loader_state_t              state_r;
  loader_state_t              state_nxt_s;
  logic [31:0]                count_r;
  logic [IDX_W-1:0]           word_idx_r;
  logic [imem_addr_width-1:0] addr_r;
  logic [instr_width-1:0]     data_r;

  logic                       pack_clr_s;
  logic                       pack_load_s;
  logic                       pack_valid_s;
  logic [LOADER_CNT_W-1:0]    pack_last_s;
  logic [PACK_W-1:0]          pack_word_s;
  logic [31:0]                hdr_count_s;
  logic [instr_width-1:0]     data_word_s;
  logic [31:0]                idx_now_s;
  logic [31:0]                idx_next_s;
  logic [imem_addr_width-1:0] idx_addr_s;

  assign hdr_count_s = pack_word_s[PACK_W-1 -: 32];
  assign data_word_s = pack_word_s[PACK_W-1 -: instr_width];
  assign idx_now_s   = 32'(word_idx_r);
  assign idx_next_s  = idx_now_s + 32'd1;
  assign idx_addr_s  = {ADDR_IDX_W'(word_idx_r), 2'b00};

  as_byte_packer #(
    .width (PACK_W)
  ) u_packer (
    .clk        (clk_i),
    .rst_n      (rst_ni),
    .clr        (pack_clr_s),
    .load       (pack_load_s),
    .byte_in    (bus.byte_i),
    .last_idx   (pack_last_s),
    .word_next  (pack_word_s),
    .word_valid (pack_valid_s)
  );

  // Next-state decode and packer control.
  always_comb begin
    state_nxt_s = state_r;
    pack_clr_s  = 1'b0;
    pack_load_s = 1'b0;
    pack_last_s = LOADER_CNT_W'(LOADER_HDR_BYTES - 1);
    case (state_r)
      ST_IDLE, ST_DONE, ST_ERR: begin
        if (bus.start_i) begin
          state_nxt_s = ST_HDR;
          pack_clr_s  = 1'b1;
        end else begin
          state_nxt_s = state_r;
        end
      end
      ST_HDR: begin
        pack_load_s = bus.byte_valid_i;
        if (pack_valid_s) begin
          if (hdr_count_s == 32'd0) begin
            state_nxt_s = ST_DONE;
          end else if (hdr_count_s > 32'(mdepth)) begin
            state_nxt_s = ST_ERR;
          end else begin
            state_nxt_s = ST_DATA;
          end
        end else begin
          state_nxt_s = ST_HDR;
        end
      end
      ST_DATA: begin
        pack_load_s = bus.byte_valid_i;
        pack_last_s = LOADER_CNT_W'(WORD_BYTES - 1);
        if (pack_valid_s) begin
          state_nxt_s = ST_WRITE;
        end else begin
          state_nxt_s = ST_DATA;
        end
      end
      ST_WRITE: begin
`ifdef AS_IMEM_LOADER_VERIFY_EN
        state_nxt_s = ST_VERIFY;
`else
        if (idx_next_s == count_r) begin
          state_nxt_s = ST_DONE;
        end else begin
          state_nxt_s = ST_DATA;
        end
`endif
      end
      ST_VERIFY: begin
`ifdef AS_IMEM_LOADER_VERIFY_EN
        // word_idx_r has already advanced past the word being checked
        if (bus.imem_data_i != data_r) begin
          state_nxt_s = ST_ERR;
        end else if (idx_now_s == count_r) begin
          state_nxt_s = ST_DONE;
        end else begin
          state_nxt_s = ST_DATA;
        end
`else
        state_nxt_s = ST_IDLE;
`endif
      end
      default: begin
        state_nxt_s = ST_IDLE;
      end
    endcase
  end

  // State register.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Word index: cleared on start, advanced once per WRITE.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      word_idx_r <= {IDX_W{1'b0}};
    end else if (pack_clr_s) begin
      word_idx_r <= {IDX_W{1'b0}};
    end else if (state_r == ST_WRITE) begin
      word_idx_r <= word_idx_r + {{(IDX_W-1){1'b0}}, 1'b1};
    end
  end

  // Latch the word count when the final header byte arrives.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      count_r <= 32'd0;
    end else if ((state_r == ST_HDR) && pack_valid_s) begin
      count_r <= hdr_count_s;
    end
  end

  // Register write address/data on the last data byte so WRITE drives them
  // directly from flops; they stay put through VERIFY for the readback.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      addr_r <= {imem_addr_width{1'b0}};
      data_r <= {instr_width{1'b0}};
    end else if ((state_r == ST_DATA) && pack_valid_s) begin
      addr_r <= idx_addr_s;
      data_r <= data_word_s;
    end
  end

`ifndef AS_IMEM_LOADER_VERIFY_EN
  logic unused_rdata_s;
  assign unused_rdata_s = ^bus.imem_data_i;
`endif

  assign bus.byte_ready_o = (state_r == ST_HDR) || (state_r == ST_DATA);
  assign bus.imem_wr_o    = (state_r == ST_WRITE);
  assign bus.imem_addr_o  = addr_r;
  assign bus.imem_data_o  = data_r;
  assign bus.busy_o       = (state_r == ST_HDR) || (state_r == ST_DATA) ||
                            (state_r == ST_WRITE) || (state_r == ST_VERIFY);
  assign bus.done_o       = (state_r == ST_DONE);
  assign bus.err_o        = (state_r == ST_ERR);
  assign bus.core_hold_o  = (state_r != ST_DONE);

endmodule

// File: tb/tb_as_imem_loader.sv
// Self-checking bench for as_imem_loader: randomized byte streams and gaps,
// expected writes and final status derived from the image byte list.
module tb_as_imem_loader;
  import as_imem_loader_pkg::*;

  localparam int MDEPTH = IMEMDEPTH;
`ifdef AS_IMEM_LOADER_VERIFY_EN
  localparam int POST = 2;
`else
  localparam int POST = 1;
`endif

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  as_imem_loader_if bus ();

  as_imem_loader dut (
    .clk_i  (clk),
    .rst_ni (rst_n),
    .bus    (bus)
  );

  logic [31:0] mem [0:MDEPTH-1];
  logic        corrupt_en = 1'b0;
  int          n_checks = 0;
  int          n_errors = 0;
  logic [7:0]  img_q [$];
  logic [31:0] got_addr_q [$];
  logic [31:0] got_data_q [$];

  // IMem stand-in: combinational read, optional forced bad readback at addr 0
  assign bus.imem_data_i = (corrupt_en && !bus.imem_wr_o && (bus.imem_addr_o == 12'h000)) ?
                           32'hDEADBEEF : mem[bus.imem_addr_o[IMEM_ADDR_WIDTH-1:2]];

  always @(posedge clk) begin
    if (bus.imem_wr_o) mem[bus.imem_addr_o[IMEM_ADDR_WIDTH-1:2]] <= bus.imem_data_o;
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Write monitor, sampled mid-cycle
  always @(negedge clk) begin
    if (rst_n && bus.imem_wr_o) begin
      got_addr_q.push_back(32'(bus.imem_addr_o));
      got_data_q.push_back(bus.imem_data_o);
      check_eq("ready_in_write", 32'(bus.byte_ready_o), 32'd0);
    end
  end

  function automatic logic [31:0] model_word(input int i);
    return {img_q[4*i+3], img_q[4*i+2], img_q[4*i+1], img_q[4*i]};
  endfunction

  task automatic check_reset_values(input string tag);
    check_eq({tag, "_ready"}, 32'(bus.byte_ready_o), 32'd0);
    check_eq({tag, "_wr"},    32'(bus.imem_wr_o),    32'd0);
    check_eq({tag, "_addr"},  32'(bus.imem_addr_o),  32'd0);
    check_eq({tag, "_data"},  bus.imem_data_o,       32'd0);
    check_eq({tag, "_busy"},  32'(bus.busy_o),       32'd0);
    check_eq({tag, "_done"},  32'(bus.done_o),       32'd0);
    check_eq({tag, "_err"},   32'(bus.err_o),        32'd0);
    check_eq({tag, "_hold"},  32'(bus.core_hold_o),  32'd1);
  endtask

  task automatic pulse_start();
    bus.start_i = 1'b1;
    @(posedge clk); #1;
    bus.start_i = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] b, input int max_gap);
    int gap;
    int waited;
    bit taken;
    gap = (max_gap > 0) ? int'($urandom_range(max_gap, 0)) : 0;
    repeat (gap) begin @(posedge clk); #1; end
    bus.byte_i       = b;
    bus.byte_valid_i = 1'b1;
    taken  = 1'b0;
    waited = 0;
    while (!taken && (waited < 50)) begin
      if (bus.byte_ready_o) taken = 1'b1;
      @(posedge clk); #1;
      waited++;
    end
    bus.byte_valid_i = 1'b0;
    if (!taken) check_eq("accept_timeout", 32'd0, 32'd1);
  endtask

  task automatic make_image(input int nwords);
    img_q.delete();
    for (int i = 0; i < nwords * 4; i++) img_q.push_back(8'($urandom_range(255, 0)));
  endtask

  task automatic load_directed_image();
    img_q.delete();
    img_q = '{8'h13, 8'h01, 8'h50, 8'h00, 8'h93, 8'h01, 8'hC0, 8'h00};
  endtask

  // Full load from start pulse to final status; img_q holds cnt words of bytes.
  task automatic run_load(input logic [31:0] cnt, input int max_gap, input bit corrupt);
    int exp_n;
    int n_bytes;
    bit exp_err;
    got_addr_q.delete();
    got_data_q.delete();
    corrupt_en = corrupt;
    if (cnt == 32'd0) begin
      exp_n = 0; exp_err = 1'b0;
    end else if (cnt > 32'(MDEPTH)) begin
      exp_n = 0; exp_err = 1'b1;
    end else if (corrupt) begin
      exp_n = 1; exp_err = 1'b1;
    end else begin
      exp_n = int'(cnt); exp_err = 1'b0;
    end
    pulse_start();
    check_eq("start_busy", 32'(bus.busy_o), 32'd1);
    check_eq("start_done_clr", 32'(bus.done_o), 32'd0);
    check_eq("start_err_clr", 32'(bus.err_o), 32'd0);
    check_eq("start_hold", 32'(bus.core_hold_o), 32'd1);
    for (int i = 0; i < 4; i++) send_byte(cnt[8*i +: 8], max_gap);
    if ((cnt == 32'd0) || (cnt > 32'(MDEPTH))) begin
      check_eq("hdr_done", 32'(!exp_err), 32'(bus.done_o) ^ 32'd0);
      check_eq("hdr_err", 32'(bus.err_o), 32'(exp_err));
    end else begin
      n_bytes = corrupt ? 4 : int'(cnt) * 4;
      for (int i = 0; i < n_bytes; i++) send_byte(img_q[i], max_gap);
      check_eq("wr_latency", 32'(bus.imem_wr_o), 32'd1);
      check_eq("ready_low_write", 32'(bus.byte_ready_o), 32'd0);
      repeat (POST) begin @(posedge clk); #1; end
      check_eq("end_done", 32'(bus.done_o), 32'(!exp_err));
      check_eq("end_err", 32'(bus.err_o), 32'(exp_err));
    end
    @(posedge clk); #1;
    check_eq("n_writes", 32'(got_addr_q.size()), 32'(exp_n));
    for (int i = 0; (i < exp_n) && (i < got_addr_q.size()); i++) begin
      check_eq("wr_addr", got_addr_q[i], 32'(i * 4));
      check_eq("wr_data", got_data_q[i], model_word(i));
    end
    check_eq("end_hold", 32'(bus.core_hold_o), 32'(exp_err));
    check_eq("end_busy", 32'(bus.busy_o), 32'd0);
    corrupt_en = 1'b0;
  endtask

  initial begin
    bus.start_i      = 1'b0;
    bus.byte_i       = 8'h00;
    bus.byte_valid_i = 1'b0;
    for (int i = 0; i < MDEPTH; i++) mem[i] = 32'd0;
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check_reset_values("rst");
    rst_n = 1'b1;
    @(posedge clk); #1;

    // directed two-word image
    load_directed_image();
    run_load(32'd2, 0, 1'b0);
    check_eq("img_word0", mem[0], 32'h00500113);
    check_eq("img_word1", mem[1], 32'h00C00193);

    // empty image and oversize header
    run_load(32'd0, 0, 1'b0);
    run_load(32'(MDEPTH + 1), 0, 1'b0);

    // same image with 0..7 cycle valid gaps
    load_directed_image();
    run_load(32'd2, 7, 1'b0);

    // random images with random gaps
    for (int k = 0; k < 6; k++) begin
      int n;
      n = int'($urandom_range(6, 1));
      make_image(n);
      run_load(32'(n), int'($urandom_range(3, 0)), 1'b0);
    end

`ifdef AS_IMEM_LOADER_VERIFY_EN
    load_directed_image();
    run_load(32'd2, 0, 1'b1);
`endif

    // reset in the middle of the data phase
    load_directed_image();
    pulse_start();
    for (int i = 0; i < 4; i++) send_byte(((i == 0) ? 8'h02 : 8'h00), 0);
    for (int i = 0; i < 6; i++) send_byte(img_q[i], 0);
    rst_n = 1'b0;
    #1;
    check_reset_values("midrst");
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    make_image(3);
    run_load(32'd3, 2, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
